muldiv_sequencer: RTL and testbench

- Iterative multi-cycle multiply/divide engine and its controller for the 64-bit CPU datapath.
- Takes over the ALU_MUL/ALU_DIV decodes from the control unit: one shift-add/restoring iteration per cycle.
- Holds the PC and register-file write via a stall output until the result is ready.
- Sits beside the ALU; the writeback mux selects its result when done is high.

---
 rtl/muldiv_sequencer.sv | 137 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide engine for the 64-bit CPU datapath.
// It performs one shift-add (multiply) or restoring (divide) step per cycle
// and stalls the pipeline until the result is committed in the DONE cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic            op_r;
  // hi/lo form one 2*WIDTH working register:
  //   multiply: {hi, lo} = partial product, lo starts as the multiplier
  //   divide:   hi = partial remainder, lo = dividend shifting into quotient
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;          // multiplicand or divisor
  logic [2*WIDTH-1:0] step_nxt;

  // One shift-add step: conditionally add multiplicand to the upper half,
  // then shift the whole {carry, hi, lo} right by one.
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [WIDTH-1:0] h,
    input logic [WIDTH-1:0] l,
    input logic [WIDTH-1:0] addend
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, h} + {1'b0, (l[0] ? addend : {WIDTH{1'b0}})};
    return {sum, l[WIDTH-1:1]};
  endfunction

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and subtract the divisor if it fits.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] h,
    input logic [WIDTH-1:0] l,
    input logic [WIDTH-1:0] divisor
  );
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {h, l[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (shifted >= {1'b0, divisor})
      return {diff[WIDTH-1:0], l[WIDTH-2:0], 1'b1};
    else
      return {shifted[WIDTH-1:0], l[WIDTH-2:0], 1'b0};
  endfunction

  // Next value of the working register for the current iteration
  always_comb begin
    step_nxt = op_r ? div_step(hi, lo, opnd) : mul_step(hi, lo, opnd);
  end

  // The issuing cycle must already freeze the PC, so stall follows start in IDLE
  assign stall = (state == S_IDLE) ? start : (state == S_RUN);

  // Controller FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      counter     <= '0;
      op_r        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r    <= op;
            counter <= '0;
            if (op && (b == '0)) begin
              state       <= S_DONE;
              done        <= 1'b1;
              result      <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH - 1)) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            result      <= step_nxt[WIDTH-1:0];
            remainder   <= op_r ? step_nxt[2*WIDTH-1:WIDTH] : '0;
            div_by_zero <= 1'b0;
          end
        end
        S_DONE: begin
          // Same instruction is retiring; start still high must not relaunch
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath working registers; contents are don't-care outside RUN
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      hi   <= '0;
      lo   <= op ? a : b;
      opnd <= op ? b : a;
    end else if (state == S_RUN) begin
      {hi, lo} <= step_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: timing of stall/busy/done,
// multiply and divide results, divide by zero, back-to-back and reset.
module tb_muldiv_sequencer;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec  = 0;
  int n_miss = 0;

  // Observations collected by run_seq
  int           stall_cnt;
  int           busy_cnt;
  int           done_cnt;
  int           done_at  [2];
  logic [W-1:0] res_q    [2];
  logic [W-1:0] rem_q    [2];
  logic         dz_q     [2];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue op1 in cycle 0 and hold start like a CPU would (issue, RUN, DONE),
  // scrambling op/a/b after the accept. Optionally issue op2 in the IDLE
  // cycle right after the first DONE. Cycle k=0 is the issue cycle.
  task automatic run_seq(input logic o1, input logic [W-1:0] x1, input logic [W-1:0] y1,
                         input bit second, input logic o2, input logic [W-1:0] x2,
                         input logic [W-1:0] y2, input int ncyc);
    bit launched2;
    launched2 = 1'b0;
    stall_cnt = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
    for (int i = 0; i < 2; i++) begin
      done_at[i] = -1;
      res_q[i]   = '0;
      rem_q[i]   = '0;
      dz_q[i]    = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < ncyc; k++) begin
      if (k == 0) begin
        start = 1'b1; op = o1; a = x1; b = y1;
      end else if (done_cnt == 0) begin
        start = 1'b1; op = ~o1; a = ~x1; b = y1 ^ 64'h5A;
      end else if (done_cnt == 1 && second && !launched2) begin
        start = 1'b1; op = o2; a = x2; b = y2;
        launched2 = 1'b1;
      end else if (done_cnt == 1 && launched2) begin
        start = 1'b1; op = ~o2; a = ~x2; b = y2 ^ 64'hA5;
      end else begin
        start = 1'b0;
      end
      #1;
      if (k == 0) check_vec("issue_stall", 64'(stall), 64'd1);
      if (stall) stall_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        if (done_cnt < 2) begin
          done_at[done_cnt] = k;
          res_q[done_cnt]   = result;
          rem_q[done_cnt]   = remainder;
          dz_q[done_cnt]    = div_by_zero;
        end
        done_cnt++;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int dseen;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    check_vec("rst_stall",  64'(stall), 64'd0);
    check_vec("rst_busy",   64'(busy), 64'd0);
    check_vec("rst_done",   64'(done), 64'd0);
    check_vec("rst_result", result, 64'd0);
    check_vec("rst_rem",    remainder, 64'd0);
    check_vec("rst_dz",     64'(div_by_zero), 64'd0);
    rst = 1'b0;

    // MUL 7*6
    run_seq(1'b0, 64'd7, 64'd6, 1'b0, 1'b0, '0, '0, 75);
    check_vec("mul_stall_cycles", 64'(stall_cnt), 64'd65);
    check_vec("mul_busy_cycles",  64'(busy_cnt), 64'd64);
    check_vec("mul_done_count",   64'(done_cnt), 64'd1);
    check_vec("mul_done_cycle",   64'(done_at[0]), 64'd65);
    check_vec("mul_result",       res_q[0], 64'd42);
    check_vec("mul_rem",          rem_q[0], 64'd0);
    check_vec("mul_dz",           64'(dz_q[0]), 64'd0);
    #1;
    check_vec("mul_hold_idle",    result, 64'd42);

    // MUL overflow keeps only the low half
    run_seq(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, '0, '0, 75);
    check_vec("mulovf_result", res_q[0], 64'hFFFF_FFFF_FFFF_FFFE);
    check_vec("mulovf_rem",    rem_q[0], 64'd0);
    check_vec("mulovf_done_count", 64'(done_cnt), 64'd1);

    // DIV 100/7, operands scrambled during RUN
    run_seq(1'b1, 64'd100, 64'd7, 1'b0, 1'b0, '0, '0, 75);
    check_vec("div_result",     res_q[0], 64'd14);
    check_vec("div_rem",        rem_q[0], 64'd2);
    check_vec("div_dz",         64'(dz_q[0]), 64'd0);
    check_vec("div_done_cycle", 64'(done_at[0]), 64'd65);
    check_vec("div_stall_cycles", 64'(stall_cnt), 64'd65);

    // Divide by zero skips RUN
    run_seq(1'b1, 64'd5, 64'd0, 1'b0, 1'b0, '0, '0, 10);
    check_vec("dz_done_cycle", 64'(done_at[0]), 64'd1);
    check_vec("dz_busy_cycles", 64'(busy_cnt), 64'd0);
    check_vec("dz_stall_cycles", 64'(stall_cnt), 64'd1);
    check_vec("dz_done_count", 64'(done_cnt), 64'd1);
    check_vec("dz_result",     res_q[0], 64'hFFFF_FFFF_FFFF_FFFF);
    check_vec("dz_rem",        rem_q[0], 64'd5);
    check_vec("dz_flag",       64'(dz_q[0]), 64'd1);

    // Back-to-back: DIV 9/3, then MUL 3*3 issued in the IDLE cycle after DONE
    run_seq(1'b1, 64'd9, 64'd3, 1'b1, 1'b0, 64'd3, 64'd3, 140);
    check_vec("b2b_done_count", 64'(done_cnt), 64'd2);
    check_vec("b2b_res0",  res_q[0], 64'd3);
    check_vec("b2b_rem0",  rem_q[0], 64'd0);
    check_vec("b2b_res1",  res_q[1], 64'd9);
    check_vec("b2b_rem1",  rem_q[1], 64'd0);
    check_vec("b2b_done1_cycle", 64'(done_at[1]), 64'd131);

    // Reset at RUN cycle 10 abandons the operation
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 64'd123; b = 64'd456;
    repeat (10) @(negedge clk);
    #1;
    check_vec("prerst_busy", 64'(busy), 64'd1);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_vec("midrst_stall",  64'(stall), 64'd0);
    check_vec("midrst_busy",   64'(busy), 64'd0);
    check_vec("midrst_done",   64'(done), 64'd0);
    check_vec("midrst_result", result, 64'd0);
    check_vec("midrst_rem",    remainder, 64'd0);
    dseen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      #1;
      if (done || busy) dseen++;
    end
    check_vec("midrst_no_done", 64'(dseen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
